// File: rtl/key_sequence_controller.sv
// Push-button front end: per-key synchronise/debounce/edge pipeline, lowest-index
// arbitration, and assembly of accepted key indices into a code word with valid/ready handoff.
module key_sequence_controller #(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_LEN        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int KEY_BITS       = $clog2(NUM_KEYS),
  localparam int CNT_BITS       = $clog2(CODE_LEN + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_KEYS-1:0]          key,
  input  logic                         clear,
  input  logic                         code_ready,
  output logic                         code_valid,
  output logic [CODE_LEN*KEY_BITS-1:0] code,
  output logic [CNT_BITS-1:0]          digit_count,
  output logic                         key_event,
  output logic [KEY_BITS-1:0]          key_index,
  output logic                         busy
);

  localparam int DB_BITS = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} state_t;

  logic [NUM_KEYS-1:0] press;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic               sync1_q, sync1_d, sync2_q, sync2_d;
    logic               deb_q, deb_d, deb_dly_q, deb_dly_d, press_q, press_d;
    logic [DB_BITS-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced level disagrees with the accepted level.
    always_comb begin
      sync1_d   = key[gi];
      sync2_d   = sync1_q;
      deb_dly_d = deb_q;
      press_d   = deb_q & ~deb_dly_q;
      deb_d     = deb_q;
      cnt_d     = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_BITS'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        press_q   <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        deb_q     <= deb_d;
        deb_dly_q <= deb_dly_d;
        press_q   <= press_d;
        cnt_q     <= cnt_d;
      end
    end

    assign press[gi] = press_q;
  end

  state_t                       state_q, state_d;
  logic [CODE_LEN*KEY_BITS-1:0] code_q, code_d;
  logic [CNT_BITS-1:0]          count_q, count_d;
  logic                         key_event_q, key_event_d;
  logic [KEY_BITS-1:0]          key_index_q, key_index_d;
  logic                         win_valid;
  logic [KEY_BITS-1:0]          win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    // Scanning downwards leaves the lowest pressed index as the winner.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) begin
        win_valid = 1'b1;
        win_idx   = KEY_BITS'(i);
      end
    end

    state_d     = state_q;
    code_d      = code_q;
    count_d     = count_q;
    key_event_d = 1'b0;
    key_index_d = '0;

    if (clear) begin
      state_d = IDLE;
      code_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (win_valid) begin
            key_event_d = 1'b1;
            key_index_d = win_idx;
            for (int s = 0; s < CODE_LEN; s++) begin
              if (count_q == CNT_BITS'(s)) begin
                code_d[s*KEY_BITS +: KEY_BITS] = win_idx;
              end
            end
            count_d = count_q + 1'b1;
            state_d = (count_q == CNT_BITS'(CODE_LEN - 1)) ? PRESENT : COLLECT;
          end
        end
        PRESENT: begin
          if (code_ready) begin
            state_d = IDLE;
            code_d  = '0;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = '0;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= '0;
      count_q     <= '0;
      key_event_q <= 1'b0;
      key_index_q <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      count_q     <= count_d;
      key_event_q <= key_event_d;
      key_index_q <= key_index_d;
    end
  end

  assign code_valid  = (state_q == PRESENT);
  assign busy        = (state_q != IDLE);
  assign code        = code_q;
  assign digit_count = count_q;
  assign key_event   = key_event_q;
  assign key_index   = key_index_q;

endmodule

// File: doc/key_sequence_controller.md
Name: key_sequence_controller

Overview:
Front-end controller for the push-button inputs of the lock datapath. Per key it runs a synchronise, debounce and rising-edge filter pipeline, then arbitrates simultaneous presses. Accepted key indices are sequenced into a CODE_LEN-digit code word, which is handed to the downstream lock/compare FSM over a valid/ready handshake.

Parameters:
NUM_KEYS, 4, number of raw key inputs (>=2)
CODE_LEN, 4, digits per code word (>=1)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (>=1; 5 ms at 50 MHz)
KEY_BITS (localparam), clog2(NUM_KEYS), width of one digit

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
key  input  NUM_KEYS  raw key levels, active-high (already inverted at top level), asynchronous to clock
clear  input  1  synchronous abort of the current entry
code_ready  input  1  downstream ready to take code
code_valid  output  1  complete code held on code
code  output  CODE_LEN*KEY_BITS  packed code; digit i in bits [i*KEY_BITS +: KEY_BITS]
digit_count  output  clog2(CODE_LEN+1)  digits captured so far
key_event  output  1  one-cycle pulse per accepted press
key_index  output  KEY_BITS  index of the accepted key, valid with key_event
busy  output  1  entry in progress or code awaiting handoff

Behaviour:
- Reset (async, immediate, no clock edge needed): all outputs 0. State IDLE. Sync flops, debounced levels and counters 0, so keys are treated as released.
- Sync: 2-flop synchroniser per key.
- Debounce per key:
  - Counter increments while the synced level differs from the debounced level; it clears when they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press and release are both debounced.
- Edge: press pulse = debounced & ~debounced_delayed, one cycle wide. A held key never repeats.
- Arbitration: with several press pulses in the same cycle, the lowest index wins. Losers are discarded, not queued.
- Latency: for a bounce-free input, key_event and key_index are high for exactly one cycle, beginning DEBOUNCE_CYCLES+3 rising edges after the first edge that samples key high. The digit_count and code updates are visible in the same cycle.
- FSM states: IDLE, COLLECT, PRESENT.
  - IDLE: on an accepted press, store the index in slot 0 and set digit_count=1. Go to COLLECT, or to PRESENT if CODE_LEN==1.
  - COLLECT: on an accepted press, store the index in slot digit_count and increment digit_count. When digit_count reaches CODE_LEN, go to PRESENT.
  - PRESENT: code_valid=1, with code and digit_count held stable. Presses are ignored: no key_event, no store. On code_valid & code_ready, go to IDLE; next cycle code_valid=0, code=0, digit_count=0.
- busy = (state != IDLE).
- clear has priority over everything except reset. From any state it forces IDLE, code=0, digit_count=0, code_valid=0 on the next edge. A press accepted in the same cycle is dropped and key_event stays 0. Debounce state is unaffected.
- Unfilled code slots read 0.
- code_ready is ignored outside PRESENT.

Test Plan:
(Overrides: DEBOUNCE_CYCLES=4, NUM_KEYS=4, CODE_LEN=4 -> 8-bit code.)
1. Clean press: key[2] high at edge 0, held 20 cycles -> key_event single pulse at edge 7, key_index=2, digit_count=1, busy=1. Release, then hold again -> exactly one more event.
2. Bounce: key[1] toggles 1,1,1,0,1,1,1,0 (runs shorter than 4) then stays 0 -> no key_event, digit_count unchanged.
3. Full entry: press keys 3,1,0,2 with releases, code_ready=0.
   - Expect code_valid=1, code=8'h87, digit_count=4.
   - Extra press of key[1] -> no event, code still 8'h87.
   - code_ready=1 for one cycle -> next cycle code_valid=0, code=0, digit_count=0, busy=0.
4. Simultaneous: key[3] and key[0] driven identically -> one key_event, key_index=0, digit_count=1.
5. Clear:
   - After 2 digits, clear pulse -> digit_count=0, code=0, busy=0.
   - clear asserted in the cycle of an accepted press -> key_event=0, digit_count=0.
6. Async reset: assert reset mid-cycle while in PRESENT -> code_valid, code, digit_count and busy go 0 before the next clock edge. Deassert, then a new press -> normal event at DEBOUNCE_CYCLES+3 latency.
